cypher_nibble_tx: RTL and testbench

Transmit side of the 4-bit cypher link. The block takes a 16-bit cypher word and sends it as four 4-bit nibbles, least-significant nibble first (cypher[3:0], then [7:4], [11:8], [15:12]). Each nibble is presented with a read strobe under a valid/ack handshake. The block feeds the cypher-detecting control unit on the receive side, and supports an optional inter-nibble gap, frame repetition and abort.

---
 rtl/cypher_nibble_tx_if.sv | 25 ++
 rtl/cypher_nibble_tx.sv | 154 +++++++++++++++
 tb/tb_cypher_nibble_tx.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cypher_nibble_tx_if.sv
// Bus bundle for the cypher nibble transmitter: host request side,
// receiver handshake and status outputs.
// The frame-repeat count is named "repeats" because "repeat" is a
// reserved word in SystemVerilog.
interface cypher_nibble_tx_if;
   logic [15:0] cypher;
   logic [3:0]  repeats;
   logic        start;
   logic        abort;
   logic        ack;
   logic [3:0]  nibble_out;
   logic        read;
   logic        busy;
   logic        done;

   modport master (
      input  cypher, repeats, start, abort, ack,
      output nibble_out, read, busy, done
   );

   modport slave (
      output cypher, repeats, start, abort, ack,
      input  nibble_out, read, busy, done
   );
endinterface

// File: rtl/cypher_nibble_tx.sv
// Transmit side of the 4-bit cypher link. A 16-bit word is sent as four
// nibbles, LS nibble first, each under a read/ack handshake. Supports an
// optional idle gap after each accepted nibble (except the last one of the
// last frame), frame repetition and a synchronous abort.
// All outputs are registered. They are computed from the next state so
// that a start seen on edge t0 presents the first nibble right after t0.
module cypher_nibble_tx #(
   parameter int GAP_CYCLES = 0,
   parameter int GAP_W      = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   cypher_nibble_tx_if.master   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic             GAP_EN   = (GAP_CYCLES != 0);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   state_t           state_r, state_s;
   logic [15:0]      shadow_r, shadow_s;
   logic [3:0]       frames_r, frames_s;
   logic [1:0]       index_r, index_s;
   logic [GAP_W-1:0] gap_r, gap_s;

   logic [3:0]       nibble_r, nibble_s;
   logic             read_r, read_s;
   logic             busy_r, busy_s;
   logic             done_r, done_s;
   logic [3:0]       sel_s;

   // State register plus datapath and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r  <= IDLE;
         shadow_r <= 16'h0000;
         frames_r <= 4'h0;
         index_r  <= 2'd0;
         gap_r    <= '0;
         nibble_r <= 4'h0;
         read_r   <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         shadow_r <= shadow_s;
         frames_r <= frames_s;
         index_r  <= index_s;
         gap_r    <= gap_s;
         nibble_r <= nibble_s;
         read_r   <= read_s;
         busy_r   <= busy_s;
         done_r   <= done_s;
      end
   end

   // Next-state and datapath update; abort outside IDLE beats everything.
   always_comb begin
      state_s  = state_r;
      shadow_s = shadow_r;
      frames_s = frames_r;
      index_s  = index_r;
      gap_s    = gap_r;
      case (state_r)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_s  = SEND;
               shadow_s = bus.cypher;
               frames_s = bus.repeats;
               index_s  = 2'd0;
               gap_s    = '0;
            end else begin
               state_s = IDLE;
            end
         end
         SEND: begin
            if (bus.abort) begin
               state_s = IDLE;
               index_s = 2'd0;
            end else if (bus.ack) begin
               if ((index_r == 2'd3) && (frames_r == 4'd0)) begin
                  state_s = DONE;
               end else begin
                  // Advance on the accepting edge; the gap only delays
                  // presentation of the already-selected next nibble.
                  if (index_r == 2'd3) begin
                     index_s  = 2'd0;
                     frames_s = frames_r - 4'd1;
                  end else begin
                     index_s = index_r + 2'd1;
                  end
                  gap_s = '0;
                  if (GAP_EN) begin
                     state_s = GAP;
                  end else begin
                     state_s = SEND;
                  end
               end
            end else begin
               state_s = SEND;
            end
         end
         GAP: begin
            if (bus.abort) begin
               state_s = IDLE;
               index_s = 2'd0;
            end else if (gap_r == GAP_LAST) begin
               state_s = SEND;
               gap_s   = '0;
            end else begin
               gap_s = gap_r + {{(GAP_W-1){1'b0}}, 1'b1};
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Output values for the coming cycle, derived from the next state.
   always_comb begin
      sel_s = 4'h0;
      case (index_s)
         2'd0:    sel_s = shadow_s[3:0];
         2'd1:    sel_s = shadow_s[7:4];
         2'd2:    sel_s = shadow_s[11:8];
         2'd3:    sel_s = shadow_s[15:12];
         default: sel_s = 4'h0;
      endcase
      read_s = (state_s == SEND);
      busy_s = (state_s == SEND) || (state_s == GAP);
      done_s = (state_s == DONE);
      if (read_s) begin
         nibble_s = sel_s;
      end else begin
         nibble_s = 4'h0;
      end
   end

   assign bus.nibble_out = nibble_r;
   assign bus.read       = read_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;

endmodule

// File: tb/tb_cypher_nibble_tx.sv
// Scoreboard bench for cypher_nibble_tx: one instance without gap, one
// with a 2-cycle gap. Stimulus pushes expected nibbles/done markers into
// per-instance queues; negedge monitors pop and compare on every
// accepted nibble and every done pulse.
module tb_cypher_nibble_tx;

   localparam logic [4:0] DONE_CODE = 5'h10;

   logic clock;
   logic reset;
   int   tests;
   int   fails;

   logic [4:0] q0[$];
   logic [4:0] q2[$];

   cypher_nibble_tx_if if0();
   cypher_nibble_tx_if if2();

   cypher_nibble_tx #(.GAP_CYCLES(0), .GAP_W(4)) dut0 (
      .clock (clock),
      .reset (reset),
      .bus   (if0)
   );

   cypher_nibble_tx #(.GAP_CYCLES(2), .GAP_W(4)) dut2 (
      .clock (clock),
      .reset (reset),
      .bus   (if2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_word(input int which, input logic [15:0] w, input logic [3:0] r);
      logic [15:0] v;
      v = w;
      for (int f = 0; f <= int'(r); f++) begin
         for (int k = 0; k < 4; k++) begin
            if (which == 0) q0.push_back({1'b0, v[4*k +: 4]});
            else            q2.push_back({1'b0, v[4*k +: 4]});
         end
      end
      if (which == 0) q0.push_back(DONE_CODE);
      else            q2.push_back(DONE_CODE);
   endtask

   task automatic start0(input logic [15:0] w, input logic [3:0] r);
      if0.cypher  = w;
      if0.repeats = r;
      if0.start   = 1'b1;
      tick();
      if0.start   = 1'b0;
   endtask

   task automatic wait_done(input int which);
      logic d;
      d = 1'b0;
      for (int i = 0; i < 60; i++) begin
         d = (which == 0) ? if0.done : if2.done;
         if (d) break;
         tick();
      end
      chk(which == 0 ? "done0_reached" : "done2_reached", {15'd0, d}, 16'd1);
      tick();
   endtask

   // Scoreboard monitor for the no-gap instance.
   always @(negedge clock) begin
      logic [4:0] e;
      if (reset && !if0.abort) begin
         if (if0.read && if0.ack) begin
            if (q0.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL nib0_unexpected: got %h expected nothing", if0.nibble_out);
            end else begin
               e = q0.pop_front();
               chk("nib0", {11'd0, 1'b0, if0.nibble_out}, {11'd0, e});
            end
         end
         if (if0.done) begin
            if (q0.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL done0_unexpected: got done expected nothing");
            end else begin
               e = q0.pop_front();
               chk("done0", {11'd0, DONE_CODE}, {11'd0, e});
            end
         end
         if (!if0.read) chk("nib0_zero_idle", {12'd0, if0.nibble_out}, 16'd0);
      end
   end

   // Scoreboard monitor for the gapped instance.
   always @(negedge clock) begin
      logic [4:0] e;
      if (reset && !if2.abort) begin
         if (if2.read && if2.ack) begin
            if (q2.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL nib2_unexpected: got %h expected nothing", if2.nibble_out);
            end else begin
               e = q2.pop_front();
               chk("nib2", {11'd0, 1'b0, if2.nibble_out}, {11'd0, e});
            end
         end
         if (if2.done) begin
            if (q2.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL done2_unexpected: got done expected nothing");
            end else begin
               e = q2.pop_front();
               chk("done2", {11'd0, DONE_CODE}, {11'd0, e});
            end
         end
         if (!if2.read) chk("nib2_zero_idle", {12'd0, if2.nibble_out}, 16'd0);
      end
   end

   initial begin
      int  rc;
      int  gc;
      logic seen;
      tests = 0;
      fails = 0;
      reset = 1'b0;
      if0.cypher = 16'h0000; if0.repeats = 4'h0; if0.start = 1'b0;
      if0.abort  = 1'b0;     if0.ack     = 1'b1;
      if2.cypher = 16'h0000; if2.repeats = 4'h0; if2.start = 1'b0;
      if2.abort  = 1'b0;     if2.ack     = 1'b1;
      #1;
      chk("reset_read",   {15'd0, if0.read}, 16'd0);
      chk("reset_busy",   {15'd0, if0.busy}, 16'd0);
      chk("reset_done",   {15'd0, if0.done}, 16'd0);
      chk("reset_nibble", {12'd0, if0.nibble_out}, 16'd0);
      @(negedge clock);
      #2 reset = 1'b1;

      // Basic send: 4 read cycles, then one done cycle; start in DONE ignored.
      push_word(0, 16'hA5C3, 4'd0);
      start0(16'hA5C3, 4'd0);
      for (int k = 0; k < 4; k++) begin
         chk("basic_read", {15'd0, if0.read}, 16'd1);
         chk("basic_busy", {15'd0, if0.busy}, 16'd1);
         tick();
      end
      chk("basic_done",      {15'd0, if0.done}, 16'd1);
      chk("basic_done_busy", {15'd0, if0.busy}, 16'd0);
      if0.cypher = 16'hFFFF;
      if0.start  = 1'b1;
      tick();
      if0.start  = 1'b0;
      chk("start_in_done_ignored", {15'd0, if0.busy}, 16'd0);
      chk("done_one_cycle",        {15'd0, if0.done}, 16'd0);
      tick();

      // Backpressure: nibble C held for 3 cycles.
      push_word(0, 16'hA5C3, 4'd0);
      start0(16'hA5C3, 4'd0);
      tick();
      if0.ack = 1'b0;
      chk("bp_hold0", {11'd0, if0.read, if0.nibble_out}, 16'h001C);
      tick();
      chk("bp_hold1", {11'd0, if0.read, if0.nibble_out}, 16'h001C);
      tick();
      chk("bp_hold2", {11'd0, if0.read, if0.nibble_out}, 16'h001C);
      if0.ack = 1'b1;
      tick();
      chk("bp_next5", {12'd0, if0.nibble_out}, 16'h0005);
      tick();
      chk("bp_no_early_done", {15'd0, if0.done}, 16'd0);
      tick();
      chk("bp_done_delayed", {15'd0, if0.done}, 16'd1);
      tick();

      // Ignored start while busy.
      push_word(0, 16'hA5C3, 4'd0);
      start0(16'hA5C3, 4'd0);
      if0.cypher = 16'hFFFF;
      if0.start  = 1'b1;
      tick();
      tick();
      if0.start  = 1'b0;
      wait_done(0);
      tick();
      chk("ignored_start_idle", {15'd0, if0.busy}, 16'd0);

      // Abort after nibble 5 is accepted; ack on the same edge is discarded.
      q0.push_back(5'h03);
      q0.push_back(5'h0C);
      q0.push_back(5'h05);
      start0(16'hA5C3, 4'd0);
      tick();
      tick();
      tick();
      if0.abort = 1'b1;
      tick();
      if0.abort = 1'b0;
      chk("abort_read",   {15'd0, if0.read}, 16'd0);
      chk("abort_busy",   {15'd0, if0.busy}, 16'd0);
      chk("abort_nibble", {12'd0, if0.nibble_out}, 16'd0);
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         seen = seen | if0.done;
         tick();
      end
      chk("abort_no_done", {15'd0, seen}, 16'd0);
      if0.abort = 1'b1;
      if0.start = 1'b1;
      tick();
      if0.abort = 1'b0;
      if0.start = 1'b0;
      chk("abort_beats_start", {15'd0, if0.busy}, 16'd0);
      tick();
      push_word(0, 16'h9876, 4'd0);
      start0(16'h9876, 4'd0);
      wait_done(0);

      // Gap and repeat on the gapped instance.
      push_word(2, 16'h1234, 4'd1);
      if2.cypher  = 16'h1234;
      if2.repeats = 4'd1;
      if2.start   = 1'b1;
      tick();
      if2.start   = 1'b0;
      rc = 0;
      gc = 0;
      for (int i = 0; i < 80; i++) begin
         if (if2.done) break;
         if (if2.read) rc++;
         else if (if2.busy) gc++;
         tick();
      end
      chk("gap_read_cycles", 16'(rc), 16'd8);
      chk("gap_idle_cycles", 16'(gc), 16'd14);
      wait_done(2);
      chk("gap_single_done", {15'd0, if2.done}, 16'd0);

      // Asynchronous reset mid-frame, then a start on the first edge after release.
      q0.push_back(5'h03);
      q0.push_back(5'h0C);
      start0(16'hA5C3, 4'd0);
      tick();
      tick();
      #2 reset = 1'b0;
      #1;
      chk("areset_read",   {15'd0, if0.read}, 16'd0);
      chk("areset_busy",   {15'd0, if0.busy}, 16'd0);
      chk("areset_done",   {15'd0, if0.done}, 16'd0);
      chk("areset_nibble", {12'd0, if0.nibble_out}, 16'd0);
      @(negedge clock);
      #2;
      reset = 1'b1;
      push_word(0, 16'h0F0F, 4'd0);
      if0.cypher  = 16'h0F0F;
      if0.repeats = 4'd0;
      if0.start   = 1'b1;
      tick();
      if0.start   = 1'b0;
      chk("first_start_after_reset", {15'd0, if0.read}, 16'd1);
      wait_done(0);

      tick();
      tick();
      chk("q0_drained", 16'(q0.size()), 16'd0);
      chk("q2_drained", 16'(q2.size()), 16'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
